// File: rtl/sram_arbiter_if.sv
// Bus between sram_arbiter, its two requesters (CPU and program loader) and the
// external SRAM pins / tristate buffer.
interface sram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;

  logic        ld_req;
  logic        ld_we;
  logic [19:0] ld_addr;
  logic [15:0] ld_wdata;
  logic [15:0] ld_rdata;
  logic        ld_ack;

  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        tristate_oe;
  logic        busy;
  logic [1:0]  gnt;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  Data_from_SRAM,
    output cpu_rdata, cpu_ack, ld_rdata, ld_ack,
    output CE, UB, LB, OE, WE, ADDR, Data_to_SRAM, tristate_oe, busy, gnt
  );

  // Requester / SRAM side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output Data_from_SRAM,
    input  cpu_rdata, cpu_ack, ld_rdata, ld_ack,
    input  CE, UB, LB, OE, WE, ADDR, Data_to_SRAM, tristate_oe, busy, gnt
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and fixed-length access sequencer for the shared external
// SRAM; every output is a register, so no requester input reaches the SRAM pins.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           Clk,
  input logic           Reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic       last;
  logic       owner;
  logic       we_lat;
  logic [3:0] cnt;
  logic       pick_ld;

  // On a tie the port that was not served last wins; last = 1 means loader.
  always_comb begin
    pick_ld = bus.ld_req;
    if (bus.cpu_req && bus.ld_req) begin
      pick_ld = ~last;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state            <= IDLE;
      last             <= 1'b1;
      owner            <= 1'b0;
      we_lat           <= 1'b0;
      cnt              <= 4'd0;
      bus.CE           <= 1'b1;
      bus.UB           <= 1'b1;
      bus.LB           <= 1'b1;
      bus.OE           <= 1'b1;
      bus.WE           <= 1'b1;
      bus.ADDR         <= 20'd0;
      bus.Data_to_SRAM <= 16'd0;
      bus.tristate_oe  <= 1'b0;
      bus.busy         <= 1'b0;
      bus.gnt          <= 2'b00;
      bus.cpu_ack      <= 1'b0;
      bus.ld_ack       <= 1'b0;
      bus.cpu_rdata    <= 16'd0;
      bus.ld_rdata     <= 16'd0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.ld_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.ld_req) begin
            owner            <= pick_ld;
            bus.gnt          <= pick_ld ? 2'b10 : 2'b01;
            we_lat           <= pick_ld ? bus.ld_we : bus.cpu_we;
            bus.ADDR         <= pick_ld ? bus.ld_addr : bus.cpu_addr;
            bus.Data_to_SRAM <= pick_ld ? bus.ld_wdata : bus.cpu_wdata;
            bus.OE           <= pick_ld ? bus.ld_we : bus.cpu_we;
            bus.WE           <= pick_ld ? ~bus.ld_we : ~bus.cpu_we;
            bus.tristate_oe  <= pick_ld ? bus.ld_we : bus.cpu_we;
            bus.CE           <= 1'b0;
            bus.UB           <= 1'b0;
            bus.LB           <= 1'b0;
            bus.busy         <= 1'b1;
            cnt              <= 4'(WAIT_CYCLES - 1);
            state            <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_lat) begin
              if (owner) begin
                bus.ld_rdata <= bus.Data_from_SRAM;
              end else begin
                bus.cpu_rdata <= bus.Data_from_SRAM;
              end
            end
            bus.OE <= 1'b1;
            bus.WE <= 1'b1;
            if (owner) begin
              bus.ld_ack <= 1'b1;
            end else begin
              bus.cpu_ack <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Address, data and bus drive were held through this cycle for write hold time.
          bus.CE          <= 1'b1;
          bus.UB          <= 1'b1;
          bus.LB          <= 1'b1;
          bus.tristate_oe <= 1'b0;
          bus.busy        <= 1'b0;
          bus.gnt         <= 2'b00;
          last            <= owner;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: two instances (WAIT_CYCLES 2 and 1) are checked
// every cycle against a transaction-level model of arbitration, timing and SRAM contents.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        ce, ub, lb, oe, we, toe, busy, cpu_ack, ld_ack;
    logic [1:0]  gnt;
    logic [19:0] addr;
    logic [15:0] dout, cpu_rd, ld_rd;
  } obs_t;

  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [19:0] cpu_addr = '0, ld_addr = '0;
  logic [15:0] cpu_wdata = '0, ld_wdata = '0, d_from = '0;

  obs_t obs [2];
  obs_t o;
  assign o = obs[sel];

  // Instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=1; the idle one is held in reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      sram_arbiter_if sif ();
      assign sif.cpu_req        = cpu_req;
      assign sif.cpu_we         = cpu_we;
      assign sif.cpu_addr       = cpu_addr;
      assign sif.cpu_wdata      = cpu_wdata;
      assign sif.ld_req         = ld_req;
      assign sif.ld_we          = ld_we;
      assign sif.ld_addr        = ld_addr;
      assign sif.ld_wdata       = ld_wdata;
      assign sif.Data_from_SRAM = d_from;
      sram_arbiter #(.WAIT_CYCLES(2 - gi)) u_dut (
        .Clk   (clk),
        .Reset ((int'(sel) == gi) ? rst_n : 1'b0),
        .bus   (sif.slave)
      );
      assign obs[gi] = '{ce: sif.CE, ub: sif.UB, lb: sif.LB, oe: sif.OE, we: sif.WE,
                         toe: sif.tristate_oe, busy: sif.busy, cpu_ack: sif.cpu_ack,
                         ld_ack: sif.ld_ack, gnt: sif.gnt, addr: sif.ADDR,
                         dout: sif.Data_to_SRAM, cpu_rd: sif.cpu_rdata, ld_rd: sif.ld_rdata};
    end
  endgenerate

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // SRAM contents as seen on the pins, and as the model expects them to be.
  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] dflt(input logic [19:0] a);
    return a[15:0] ^ 16'h5A3C ^ {12'h000, a[19:16]};
  endfunction

  function automatic logic [15:0] sram_rd(input logic [19:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return dflt(a);
  endfunction

  // Reference model: m_phase counts cycles since the grant edge (0 = no access).
  int          w_cur = 2;
  int          m_phase = 0;
  logic        m_owner = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_wdata = '0, m_cpu_rd = '0, m_ld_rd = '0;

  task automatic model_edge();
    if (!rst_n) begin
      m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ld_rd = '0;
    end else if (m_phase == 0) begin
      if (cpu_req || ld_req) begin
        m_owner = (cpu_req && ld_req) ? ~m_last : ld_req;
        m_we    = m_owner ? ld_we : cpu_we;
        m_addr  = m_owner ? ld_addr : cpu_addr;
        m_wdata = m_owner ? ld_wdata : cpu_wdata;
        if (m_we) ref_mem[int'(m_addr)] = m_wdata;
        m_phase = 1;
      end
    end else if (m_phase <= w_cur) begin
      m_phase++;
      if (m_phase == w_cur + 1) begin
        if (!m_we && m_owner) m_ld_rd = ref_rd(m_addr);
        if (!m_we && !m_owner) m_cpu_rd = ref_rd(m_addr);
        $display("%0t W=%0d %s %s addr=%05h data=%04h", $time, w_cur, m_owner ? "ld " : "cpu",
                 m_we ? "wr" : "rd", m_addr, m_we ? m_wdata : ref_rd(m_addr));
      end
    end else begin
      m_last  = m_owner;
      m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    logic act, acc, done;
    act  = (m_phase != 0);
    acc  = (m_phase >= 1) && (m_phase <= w_cur);
    done = (m_phase == w_cur + 1);
    check("CE", o.ce, !act);
    check("UB", o.ub, !act);
    check("LB", o.lb, !act);
    check("OE", o.oe, !(acc && !m_we));
    check("WE", o.we, !(acc && m_we));
    check("tristate_oe", o.toe, act && m_we);
    check("ADDR", o.addr, m_addr);
    check("Data_to_SRAM", o.dout, m_wdata);
    check("busy", o.busy, act);
    check("gnt", o.gnt, act ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
    check("cpu_ack", o.cpu_ack, done && !m_owner);
    check("ld_ack", o.ld_ack, done && m_owner);
    check("cpu_rdata", o.cpu_rd, m_cpu_rd);
    check("ld_rdata", o.ld_rd, m_ld_rd);
  endtask

  // Stimulus knobs
  txn_t cpu_q[$], ld_q[$];
  bit [1:0] port_en = 2'b11;
  int p_raise = 0, p_again = 0, p_scramble = 0, p_rst = 0, rst_hold = 0;
  bit arm_rst = 1'b0;

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(1));
    t.addr  = ($urandom_range(1) != 0 ? 20'hF0000 : 20'h00120) + 20'($urandom_range(7));
    t.wdata = 16'($urandom);
    return t;
  endfunction

  task automatic set_port(input bit p, input logic r, input txn_t t);
    if (p) begin ld_req = r; ld_we = t.we; ld_addr = t.addr; ld_wdata = t.wdata; end
    else begin cpu_req = r; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata; end
  endtask

  task automatic drive_port(input bit p);
    logic granted, acked, req;
    int   qn;
    txn_t t;
    granted = (m_phase != 0) && (m_owner == p);
    acked   = granted && (m_phase == w_cur + 1);
    req     = p ? ld_req : cpu_req;
    qn      = p ? ld_q.size() : cpu_q.size();
    if (acked || (!req && !granted)) begin
      if (port_en[p] && (qn != 0 || $urandom_range(99) < (acked ? p_again : p_raise))) begin
        if (qn != 0) t = p ? ld_q.pop_front() : cpu_q.pop_front();
        else t = rand_txn();
        set_port(p, 1'b1, t);
      end else if (p) ld_req = 1'b0;
      else cpu_req = 1'b0;
    end else if (granted && $urandom_range(99) < p_scramble) begin
      // After the grant edge the requester may drop req or change its fields freely.
      set_port(p, 1'($urandom_range(1)), rand_txn());
    end
  endtask

  task automatic drive_next();
    drive_port(1'b0);
    drive_port(1'b1);
    rst_n = 1'b1;
    if (rst_hold > 0) begin
      rst_n = 1'b0;
      rst_hold--;
    end else if (arm_rst && m_phase == 2 && m_we) begin
      // Reset in the second ACCESS cycle of a write, with a tie waiting behind it.
      rst_n   = 1'b0;
      arm_rst = 1'b0;
      if (!cpu_req) set_port(1'b0, 1'b1, rand_txn());
      if (!ld_req) set_port(1'b1, 1'b1, rand_txn());
    end else if ($urandom_range(999) < p_rst) begin
      rst_n = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (!o.ce && !o.we) sram_mem[int'(o.addr)] = o.dout;
    d_from = sram_rd(o.addr);
    drive_next();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic knobs(input bit [1:0] en, input int raise, input int again, input int scr, input int prst);
    port_en = en; p_raise = raise; p_again = again; p_scramble = scr; p_rst = prst;
  endtask

  initial begin
    txn_t t;
    sram_mem[int'(20'h00123)] = 16'hBEEF;
    ref_mem[int'(20'h00123)]  = 16'hBEEF;
    rst_hold = 2;

    // Single CPU read, loader idle
    knobs(2'b01, 0, 0, 0, 0);
    t = '{we: 1'b0, addr: 20'h00123, wdata: 16'h0000};
    cpu_q.push_back(t);
    run(10);

    // Single loader write
    knobs(2'b10, 0, 0, 0, 0);
    t = '{we: 1'b1, addr: 20'hF0000, wdata: 16'h1234};
    ld_q.push_back(t);
    run(8);

    // Both ports held: alternating grants, back to back
    rst_hold = 1;
    knobs(2'b11, 100, 100, 0, 0);
    run(20);

    // Reset in the middle of a write, then a tie
    arm_rst = 1'b1;
    run(30);
    arm_rst = 1'b0;

    // Requester drops req / changes address during ACCESS
    knobs(2'b11, 40, 50, 30, 0);
    run(200);

    // Fully random traffic with occasional resets
    knobs(2'b11, 30, 40, 10, 3);
    run(2500);

    // Switch to the WAIT_CYCLES=1 instance
    sel = 1'b1;
    w_cur = 2;
    w_cur = 1;
    sram_mem.delete();
    ref_mem.delete();
    cpu_req = 1'b0;
    ld_req = 1'b0;
    rst_n = 1'b0;
    rst_hold = 2;
    knobs(2'b01, 0, 0, 0, 0);
    t = '{we: 1'b0, addr: 20'h00010, wdata: 16'h0000};
    cpu_q.push_back(t);
    t = '{we: 1'b0, addr: 20'h00011, wdata: 16'h0000};
    cpu_q.push_back(t);
    run(12);

    knobs(2'b11, 100, 100, 0, 0);
    run(20);
    knobs(2'b11, 30, 40, 10, 3);
    run(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
